// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I instruction fetch front end with PC, imem req/ack and decode valid/ready.
// Optional one-entry prefetch buffer and S_DROP state under `ifdef IFU_PREFETCH_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic [31:0] pc_target,
  output logic        fetch_misalign
);

`ifdef IFU_PREFETCH_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT, S_DROP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic        req_c;
  logic        accept;
  logic [31:0] target_aligned;

`ifdef IFU_PREFETCH_EN
  logic [31:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] redir_q, redir_d;
`endif

  assign accept         = valid_q && instr_ready;
  assign target_aligned = {pc_target[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= RESET_PC;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
`ifdef IFU_PREFETCH_EN
      buf_q       <= NOP_INSTR;
      buf_valid_q <= 1'b0;
      redir_q     <= RESET_PC;
`endif
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
`ifdef IFU_PREFETCH_EN
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      redir_q     <= redir_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    misalign_d  = 1'b0;
    req_c       = 1'b0;
`ifdef IFU_PREFETCH_EN
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    redir_d     = redir_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        req_c = 1'b1;
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
`ifdef IFU_PREFETCH_EN
        // Prefetch whenever the buffer has room; the request stays up across the accept.
        req_c = !buf_valid_q;
        if (accept && pcsrc) begin
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
          misalign_d  = |pc_target[1:0];
          if (!buf_valid_q && !imem_ack) begin
            redir_d = target_aligned;
            state_d = S_DROP;
          end else begin
            fetch_pc_d = target_aligned;
            state_d    = S_REQ;
          end
        end else if (accept) begin
          if (buf_valid_q) begin
            instr_d     = buf_q;
            instr_pc_d  = instr_pc_q + 32'd4;
            buf_valid_d = 1'b0;
          end else if (imem_ack) begin
            instr_d    = imem_rdata;
            instr_pc_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end else if (!buf_valid_q && imem_ack) begin
          buf_d       = imem_rdata;
          buf_valid_d = 1'b1;
          fetch_pc_d  = fetch_pc_q + 32'd4;
        end
`else
        if (accept) begin
          valid_d = 1'b0;
          state_d = S_REQ;
          if (pcsrc) begin
            fetch_pc_d = target_aligned;
            misalign_d = |pc_target[1:0];
          end
        end
`endif
      end
`ifdef IFU_PREFETCH_EN
      S_DROP: begin
        // Old request must complete at its original address; its data is discarded.
        req_c = 1'b1;
        if (imem_ack) begin
          fetch_pc_d = redir_q;
          state_d    = S_REQ;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req       = req_c;
  assign imem_addr      = fetch_pc_q;
  assign instr          = valid_q ? instr_q : NOP_INSTR;
  assign instr_pc       = instr_pc_q;
  assign pc_plus4       = instr_pc_q + 32'd4;
  assign instr_valid    = valid_q;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        pcsrc;
  logic [31:0] pc_target;
  logic        fetch_misalign;

  int errors = 0;
  int checks = 0;
  logic mem_auto;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pcsrc(pcsrc), .pc_target(pc_target), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1234_5000);
  endfunction

  // Zero-wait memory: acks in the first cycle a request is seen when mem_auto is set.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_ack   = mem_auto && imem_req;
    imem_rdata = (mem_auto && imem_req) ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b0; pcsrc = 1'b0; pc_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; mem_auto = 1'b1;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL rst_instr: got %h expected 00000013", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_pc_plus4: got %h expected 4", pc_plus4); end
    checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b expected 0", fetch_misalign); end
    rst = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093) begin errors++; $display("FAIL first_instr: got v=%b %h expected v=1 00500093", instr_valid, instr); end
    checks++; if (instr_pc !== 32'h0 || pc_plus4 !== 32'h4) begin errors++; $display("FAIL first_pc: got pc=%h p4=%h expected 0/4", instr_pc, pc_plus4); end
`ifndef IFU_PREFETCH_EN
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL out_no_req: got %b expected 0", imem_req); end
`endif
  endtask

`ifndef IFU_PREFETCH_EN
  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b instr=%h pc=%h req=%b expected 1/00500093/0/0", i, instr_valid, instr, instr_pc, imem_req);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL seq_req: got req=%b addr=%h expected 1/4", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h13) begin errors++; $display("FAIL seq_nop: got v=%b instr=%h expected 0/00000013", instr_valid, instr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h4) || instr_pc !== 32'h4 || pc_plus4 !== 32'h8) begin
      errors++; $display("FAIL seq_instr: got v=%b instr=%h pc=%h p4=%h expected 1/%h/4/8", instr_valid, instr, instr_pc, pc_plus4, mem_word(32'h4)); end
  endtask

  task automatic test_redirect();
    pcsrc = 1'b1; pc_target = 32'h0000_0100;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_misalign !== 1'b0) begin
      errors++; $display("FAIL redir_addr: got req=%b addr=%h mis=%b expected 1/100/0", imem_req, imem_addr, fetch_misalign); end
    pc_target = 32'h0000_0300;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin errors++; $display("FAIL redir_instr: got v=%b pc=%h expected 1/100", instr_valid, instr_pc); end
    pc_target = 32'h0000_0102;
    tick();
    checks++; if (imem_addr !== 32'h100 || fetch_misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got addr=%h mis=%b expected 100/1", imem_addr, fetch_misalign); end
    pcsrc = 1'b0;
    tick();
    checks++; if (fetch_misalign !== 1'b0 || instr_pc !== 32'h100 || instr_valid !== 1'b1) begin
      errors++; $display("FAIL misalign_end: got mis=%b pc=%h v=%b expected 0/100/1", fetch_misalign, instr_pc, instr_valid); end
  endtask

  task automatic test_wrap();
    pcsrc = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick();
    pcsrc = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
    tick();
    checks++; if (instr_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4: got pc=%h p4=%h expected fffffffc/0", instr_pc, pc_plus4); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
    instr_ready = 1'b0;
    tick();
    checks++; if (instr_pc !== 32'h0 || instr !== 32'h0050_0093) begin errors++; $display("FAIL wrap_instr: got pc=%h instr=%h expected 0/00500093", instr_pc, instr); end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b1; mem_auto = 1'b0;
    tick(); tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL pending_req: got req=%b addr=%h expected 1/4", imem_req, imem_addr); end
    rst = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h13) begin
      errors++; $display("FAIL mid_reset: got req=%b v=%b instr=%h expected 0/0/00000013", imem_req, instr_valid, instr); end
    rst = 1'b0; mem_auto = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL restart: got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093) begin errors++; $display("FAIL restart_instr: got v=%b %h expected 1/00500093", instr_valid, instr); end
  endtask
`else
  task automatic test_prefetch();
    tick();
    checks++; if (imem_req !== 1'b0 || instr_pc !== 32'h0) begin errors++; $display("FAIL pf_buf_full: got req=%b pc=%h expected 0/0", imem_req, instr_pc); end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== mem_word(32'h4)) begin errors++; $display("FAIL pf_issue4: got v=%b pc=%h", instr_valid, instr_pc); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== mem_word(32'h8)) begin errors++; $display("FAIL pf_issue8: got v=%b pc=%h", instr_valid, instr_pc); end
    mem_auto = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL pf_issue12: got v=%b pc=%h req=%b addr=%h expected 1/c/1/10", instr_valid, instr_pc, imem_req, imem_addr); end
    pcsrc = 1'b1; pc_target = 32'h40;
    tick();
    pcsrc = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL pf_drop: got req=%b addr=%h v=%b expected 1/10/0", imem_req, imem_addr, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD; mem_auto = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL pf_redir: got req=%b addr=%h v=%b expected 1/40/0", imem_req, imem_addr, instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== mem_word(32'h40)) begin
      errors++; $display("FAIL pf_target: got v=%b pc=%h instr=%h", instr_valid, instr_pc, instr); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef IFU_PREFETCH_EN
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
`else
    test_prefetch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
